// File: rtl/image_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : image_op_sequencer
//  Purpose  : Frame-level controller for the image adapter / SRAM datapath.
//             Accepts one command per frame, optionally runs a store pass,
//             then one transform pass (rotate CCW or horizontal mirror).
//             Converts the adapter's free-running scan into stream handshakes
//             and compensates for the SRAM read latency.
//  Options  : IMG_SEQ_UNDERRUN_CHK_EN - abort the frame and flag err when
//             in_valid is low during any LOAD cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module image_op_sequencer #(
    parameter int PIX_COUNT = 1048576,
    parameter int CNT_W     = 21,
    parameter int RD_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_load,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       adp_rst,
    output logic [1:0] adp_op_mode,
    output logic [7:0] adp_data_in,
    input  logic [7:0] adp_data_out,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM_L = 3'd1,
        S_LOAD  = 3'd2,
        S_ARM_X = 3'd3,
        S_XFORM = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_pix_last   = CNT_W'(PIX_COUNT - 1);
    localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [1:0]       c_op_store   = 2'b00;
    localparam logic [1:0]       c_op_rot     = 2'b01;
    localparam logic [1:0]       c_op_mir     = 2'b10;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_op;
    logic [1:0]         w_op_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_xf_act;
    logic               w_xf_term;
    logic               w_adp_rst;
    logic [1:0]         w_adp_op;
    logic               w_op_legal;
    logic [RD_LAT-1:0]  r_vld_pipe;
    logic [RD_LAT-1:0]  r_last_pipe;

    assign w_op_legal = (cmd_op == c_op_rot) || (cmd_op == c_op_mir);

`ifndef IMG_SEQ_UNDERRUN_CHK_EN
    // Without the underrun check the adapter writes whatever in_data holds.
    logic w_unused_in_valid;
    assign w_unused_in_valid = in_valid;
`endif

    // State, counter, latched op and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= c_op_store;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, pass counter and adapter control decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_err_nxt   = r_err;
        w_xf_act    = 1'b0;
        w_xf_term   = 1'b0;
        w_adp_rst   = 1'b1;
        w_adp_op    = c_op_store;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (cmd_valid) begin
                    if (w_op_legal) begin
                        w_op_nxt    = cmd_op;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = cmd_load ? S_ARM_L : S_ARM_X;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_ARM_L: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // The adapter cannot stall, so one pixel is written per cycle.
                w_adp_rst = 1'b0;
`ifdef IMG_SEQ_UNDERRUN_CHK_EN
                if (!in_valid) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else
`endif
                if (r_cnt == c_pix_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ARM_X;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_ARM_X: begin
                w_adp_op    = r_op;
                w_cnt_nxt   = '0;
                w_state_nxt = S_XFORM;
            end
            S_XFORM: begin
                w_adp_rst = 1'b0;
                w_adp_op  = r_op;
                w_xf_act  = 1'b1;
                if (r_cnt == c_pix_last) begin
                    w_xf_term   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_DRAIN: begin
                // Hold the read mode until the last SRAM read has returned.
                w_adp_rst = 1'b0;
                w_adp_op  = r_op;
                if (r_cnt == c_drain_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Align valid/last with the SRAM read data by delaying them RD_LAT cycles
    generate
        if (RD_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld_pipe  <= '0;
                    r_last_pipe <= '0;
                end else begin
                    r_vld_pipe  <= w_xf_act;
                    r_last_pipe <= w_xf_term;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld_pipe  <= '0;
                    r_last_pipe <= '0;
                end else begin
                    r_vld_pipe  <= {r_vld_pipe[RD_LAT-2:0], w_xf_act};
                    r_last_pipe <= {r_last_pipe[RD_LAT-2:0], w_xf_term};
                end
            end
        end
    endgenerate

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign in_ready    = (r_state == S_LOAD);
    assign err         = r_err;
    assign adp_rst     = w_adp_rst;
    assign adp_op_mode = w_adp_op;
    assign adp_data_in = in_data;
    assign out_data    = adp_data_out;
    assign out_valid   = r_vld_pipe[RD_LAT-1];
    assign out_last    = r_last_pipe[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_image_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_image_op_sequencer
//  Purpose  : Self-checking bench for image_op_sequencer on a reduced 4x4
//             frame, with a behavioural adapter/SRAM model and a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_image_op_sequencer;

    localparam int W      = 4;
    localparam int P      = W * W;
    localparam int CNT_W  = 5;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_load;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       adp_rst;
    logic [1:0] adp_op_mode;
    logic [7:0] adp_data_in;
    logic [7:0] adp_data_out;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    image_op_sequencer #(
        .PIX_COUNT (P),
        .CNT_W     (CNT_W),
        .RD_LAT    (RD_LAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_load     (cmd_load),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .adp_rst      (adp_rst),
        .adp_op_mode  (adp_op_mode),
        .adp_data_in  (adp_data_in),
        .adp_data_out (adp_data_out),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural adapter: free-running scan, store in mode 00, mapped read
    // with one cycle of SRAM latency otherwise.
    logic [7:0] mem [P];
    int         a_addr = 0;
    logic [7:0] a_dout = 8'h00;
    assign adp_data_out = a_dout;

    function automatic int map_src(input logic [1:0] op, input int i);
        int r, c;
        r = i / W;
        c = i % W;
        if (op == 2'b01) return c * W + (W - 1 - r);
        return r * W + (W - 1 - c);
    endfunction

    initial begin
        for (int i = 0; i < P; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (adp_rst) begin
            a_addr <= 0;
        end else begin
            a_addr <= (a_addr == P - 1) ? 0 : a_addr + 1;
            if (adp_op_mode == 2'b00) mem[a_addr] <= adp_data_in;
            else                      a_dout      <= mem[map_src(adp_op_mode, a_addr)];
        end
    end

    // Scoreboard
    logic [7:0] gold [P];
    logic [8:0] exp_q [$];
    int beats = 0;
    int lasts = 0;
    int in_ready_cycles = 0;
    int first_beat_cyc = -1;

    task automatic push_expected(input logic [1:0] op);
        int r, c, src;
        for (int i = 0; i < P; i++) begin
            r = i / W;
            c = i % W;
            src = (op == 2'b01) ? (c * W + (W - 1 - r)) : (r * W + (W - 1 - c));
            exp_q.push_back({(i == P - 1), gold[src]});
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            if (in_ready) in_ready_cycles++;
            if (out_valid) begin
                if (beats == 0) first_beat_cyc = cyc;
                beats++;
                if (out_last) lasts++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e[7:0]);
                    check_eq("out_last", out_last, e[8]);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_last"}, out_last, 0);
        check_eq({tag, "_adp_rst"}, adp_rst, 1);
        check_eq({tag, "_adp_op"}, adp_op_mode, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_out_data"}, out_data, a_dout);
    endtask

    task automatic run_frame(input logic [1:0] op, input logic ld, input logic [7:0] seed,
                             input int under_at, input bit pulse);
        int  t_acc;
        int  n;
        bit  aborted;
        aborted = 1'b0;
        beats = 0;
        lasts = 0;
        in_ready_cycles = 0;
        first_beat_cyc = -1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("cmd_ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_load  = ld;
        @(posedge clk); #1;
        t_acc     = cyc;
        cmd_valid = 1'b0;
        check_eq("busy_after_acc", busy, 1);
        check_eq("err_after_acc", err, 0);
        if (!ld) begin
            push_expected(op);
        end else begin
            @(posedge clk); #1;
            for (int k = 0; k < P; k++) begin
                in_data  = seed + 8'(k);
                in_valid = (k != under_at);
                gold[k]  = in_data;
                @(posedge clk); #1;
`ifdef IMG_SEQ_UNDERRUN_CHK_EN
                if (k == under_at) begin
                    aborted = 1'b1;
                    break;
                end
`endif
            end
            in_valid = 1'b0;
            if (!aborted) push_expected(op);
        end
        if (pulse) begin
            repeat (P / 2) @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            cmd_op    = 2'b01;
            cmd_load  = 1'b0;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 4 * P) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_done", busy, 0);
        if (aborted) begin
            check_eq("abort_err", err, 1);
            check_eq("abort_beats", beats, 0);
        end else begin
            check_eq("latency", cyc - t_acc, (ld ? P + 1 : 0) + 1 + P + RD_LAT);
            check_eq("first_beat", first_beat_cyc - t_acc, (ld ? P + 1 : 0) + 1 + RD_LAT);
            check_eq("beat_count", beats, P);
            check_eq("last_count", lasts, 1);
            check_eq("in_ready_cycles", in_ready_cycles, ld ? P : 0);
            check_eq("queue_empty", exp_q.size(), 0);
            check_eq("err_end", err, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_load  = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Rotate with store pass, ramp data
        run_frame(2'b01, 1'b1, 8'h00, -1, 1'b0);
        // Mirror of the stored frame, no store pass
        run_frame(2'b10, 1'b0, 8'h00, -1, 1'b0);

        // Illegal ops set err and leave the sequencer idle
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_load  = 1'b1;
        @(posedge clk); #1;
        check_eq("ill00_err", err, 1);
        check_eq("ill00_busy", busy, 0);
        check_eq("ill00_ready", cmd_ready, 1);
        cmd_op = 2'b11;
        @(posedge clk); #1;
        check_eq("ill11_err", err, 1);
        check_eq("ill11_busy", busy, 0);
        check_eq("ill11_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;

        // Legal command clears err; command pulse mid-XFORM is ignored
        run_frame(2'b10, 1'b1, 8'h5A, -1, 1'b1);

        // Reset asserted in the middle of LOAD
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_load  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < P / 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_vals("rst_win");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_eq("rst_rel_ready", cmd_ready, 1);
        check_eq("rst_rel_busy", busy, 0);

        // One-cycle input underrun during LOAD
        run_frame(2'b01, 1'b1, 8'h33, 10, 1'b0);
        // Fresh frame afterwards
        run_frame(2'b10, 1'b1, 8'hC0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_op_sequencer.md
# image_op_sequencer

Frame-level controller for the 1024×1024 image adapter/SRAM datapath. It accepts one command per frame from the host and drives the adapter's `op_mode` and `rst`. A command optionally streams in a new frame (store pass), then runs one read pass (rotate-CCW or horizontal mirror). It converts the adapter's free-running, one-pixel-per-cycle scan into valid/ready input and valid/last output streams, and compensates for the SRAM's 1-cycle read latency.

## Interface
- `PIX_COUNT`, 1048576: pixels per frame (IMG_W×IMG_H); one scan pass lasts exactly this many cycles.
- `CNT_W`, 21: pixel counter width; must satisfy 2^CNT_W > PIX_COUNT.
- `RD_LAT`, 1: SRAM read latency in cycles.
- `clk`  in  1  sole clock; all flops rise-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  01 = rotate CCW, 10 = horizontal mirror; 00/11 illegal.
- `cmd_load`  in  1  1 = run store pass before the transform pass.
- `in_valid`  in  1  input pixel valid.
- `in_data`  in  8  input pixel.
- `in_ready`  out  1  high exactly during LOAD.
- `out_valid`  out  1  transformed pixel valid.
- `out_data`  out  8  transformed pixel.
- `out_last`  out  1  with final pixel of the frame.
- `adp_rst`  out  1  active-high reset to the adapter; restarts its scan at (0,0).
- `adp_op_mode`  out  2  to adapter `op_mode`.
- `adp_data_in`  out  8  to adapter `data_in`; equals `in_data`.
- `adp_data_out`  in  8  from adapter `data_out`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky error; cleared when the next legal command is accepted.

## Operation
- States: IDLE, ARM_L, LOAD, ARM_X, XFORM, DRAIN.
- IDLE: `adp_rst`=1, `adp_op_mode`=00, `cmd_ready`=1.
- Handshake `cmd_valid & cmd_ready`:
  - Illegal `cmd_op`: set `err`, stay in IDLE.
  - Legal op: latch `cmd_op` and `cmd_load`, clear `err`. Go to ARM_L if `cmd_load`=1, else ARM_X.
- ARM_L (1 cycle): `adp_rst`=1, `adp_op_mode`=00, counter cleared. Then LOAD.
- LOAD: `adp_rst`=0, `adp_op_mode`=00, `in_ready`=1. One pixel is written per cycle regardless of `in_valid`, because the adapter cannot stall. Counter increments every cycle. At count PIX_COUNT-1, go to ARM_X.
- ARM_X (1 cycle): `adp_rst`=1, `adp_op_mode`=latched op, counter cleared. Then XFORM.
- XFORM: `adp_rst`=0 for PIX_COUNT cycles (addresses 0..PIX_COUNT-1). Then DRAIN.
- DRAIN: holds `adp_op_mode` for RD_LAT cycles so the last read returns. Then IDLE.
- `out_valid` is the XFORM-active flag delayed by RD_LAT. `out_data`=`adp_data_out` (combinational passthrough). `out_last` is the terminal-count flag delayed by RD_LAT.
- There is no output backpressure. The consumer must accept one pixel per cycle.
- Counter is CNT_W bits unsigned. Terminal compare is `== PIX_COUNT-1`. The counter never wraps within a pass.
- `cmd_valid` outside IDLE is ignored; no queuing.

## Timing
- Reset values: `cmd_ready`=1, `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data` follows `adp_data_out`, `adp_rst`=1, `adp_op_mode`=00, `busy`=0, `err`=0. State is IDLE.
- Command accepted at edge T: ARM state during T+1, first scan cycle at T+2.
- Load-command frame latency: 1 + PIX_COUNT + 1 + PIX_COUNT + RD_LAT cycles from acceptance to return to IDLE.
- First `out_valid` occurs RD_LAT cycles after the first XFORM cycle. Exactly PIX_COUNT consecutive valid beats, with `out_last` on the final beat.
- `rst` low mid-frame: immediate return to IDLE values. Partial SRAM contents are undefined.
- `cmd_valid` held high in IDLE with a legal op: a new frame starts each time IDLE is re-entered. Back-to-back frames have a 1-cycle IDLE gap.

## Configuration
- `IMG_SEQ_UNDERRUN_CHK_EN` defined:
  - `in_valid`=0 during any LOAD cycle sets `err`.
  - The FSM aborts to IDLE on the next edge and asserts `adp_rst`.
  - No XFORM pass runs.
- Undefined: `in_valid` is ignored. Underrun pixels are written as whatever `in_data` holds, and the sequence completes normally.

## Test plan
- Reset, then `cmd_op`=01, `cmd_load`=1, ramp data (pixel k = k mod 256) -> exactly 1048576 `out_valid` beats. Beat (r,c) equals the pixel at row c, column 1023-r. `out_last` only on beat 1048575. `busy` then drops.
- `cmd_op`=10, `cmd_load`=0 after the previous frame -> no LOAD (`in_ready` never high). Beat (r,c) equals the stored pixel at (r,1023-c).
- `cmd_op`=00, then 11 -> `err`=1, `busy` stays 0, `cmd_ready` stays 1. Next legal command -> `err`=0.
- `rst` low for 3 cycles at pixel 500000 of LOAD -> all outputs at reset values within the reset window. `cmd_ready`=1 one edge after release.
- `in_valid`=0 for one cycle at LOAD pixel 1000 -> with macro: `err`=1, return to IDLE, zero output beats. Without macro: `err`=0 and the full 1048576-beat output completes.
- `cmd_valid` pulsed mid-XFORM -> ignored; beat count is unchanged at 1048576.
